// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared combinational ALU.
// Round-robin arbitration, one transaction in flight, registered responses.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_A,
    input  logic [WIDTH-1:0] req0_B,
    input  logic [2:0]       req0_op,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_A,
    input  logic [WIDTH-1:0] req1_B,
    input  logic [2:0]       req1_op,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp0_zero,
    output logic             rsp0_err,

    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             rsp1_zero,
    output logic             rsp1_err,

    output logic [WIDTH-1:0] src_A,
    output logic [WIDTH-1:0] src_B,
    output logic [2:0]       ALU_control,
    input  logic [WIDTH-1:0] ALU_result,
    input  logic             zero,

    output logic             busy,
    output logic             grant_id
);

    // state | meaning
    // IDLE  | waiting for a request; ready offered to the arbitration winner
    // EXEC  | ALU operands driven; result captured at the end of this cycle
    // RESP  | response held on the granted rsp port until handshake
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state;
    logic             ptr;
    logic [WIDTH-1:0] res_q;
    logic             zero_q;
    logic             err_q;

    logic             any_valid;
    logic             winner;
    logic             in_idle;
    logic             rsp_fire;
    logic [WIDTH-1:0] sel_A;
    logic [WIDTH-1:0] sel_B;
    logic [2:0]       sel_op;
    logic             sel_legal;

    assign any_valid = req0_valid | req1_valid;
    assign winner    = (req0_valid & req1_valid) ? ptr : req1_valid;
    assign sel_A     = winner ? req1_A  : req0_A;
    assign sel_B     = winner ? req1_B  : req0_B;
    assign sel_op    = winner ? req1_op : req0_op;
    assign sel_legal = (sel_op != 3'b100) && (sel_op != 3'b110) && (sel_op != 3'b111);

    // Handshake outputs are gated by reset so nothing is offered while it is asserted.
    assign in_idle    = reset && (state == IDLE);
    assign req0_ready = in_idle & req0_valid & ~winner;
    assign req1_ready = in_idle & req1_valid & winner;
    assign busy       = reset && (state != IDLE);
    assign rsp0_valid = reset && (state == RESP) && !grant_id;
    assign rsp1_valid = reset && (state == RESP) && grant_id;
    assign rsp_fire   = grant_id ? rsp1_ready : rsp0_ready;

    assign rsp0_result = res_q;
    assign rsp0_zero   = zero_q;
    assign rsp0_err    = err_q;
    assign rsp1_result = res_q;
    assign rsp1_zero   = zero_q;
    assign rsp1_err    = err_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            ptr         <= 1'b0;
            grant_id    <= 1'b0;
            src_A       <= '0;
            src_B       <= '0;
            ALU_control <= 3'b000;
            res_q       <= '0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        src_A       <= sel_A;
                        src_B       <= sel_B;
                        ALU_control <= sel_op;
                        grant_id    <= winner;
                        if (sel_legal) begin
                            state <= EXEC;
                        end else begin
                            // Illegal op skips the ALU and answers with an error response.
                            res_q  <= '0;
                            zero_q <= 1'b1;
                            err_q  <= 1'b1;
                            state  <= RESP;
                        end
                    end
                end
                EXEC: begin
                    res_q  <= ALU_result;
                    zero_q <= zero;
                    err_q  <= 1'b0;
                    state  <= RESP;
                end
                RESP: begin
                    if (rsp_fire) begin
                        ptr   <= ~grant_id;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized scoreboard bench for alu_arbiter with a behavioural ALU and
// a transaction-level model of arbitration, latency and response contents.
module tb_alu_arbiter;
    localparam int W = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [W-1:0]  req0_A = '0, req0_B = '0, req1_A = '0, req1_B = '0;
    logic [2:0]    req0_op = '0, req1_op = '0;
    logic          rsp0_valid, rsp1_valid;
    logic          rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [W-1:0]  rsp0_result, rsp1_result;
    logic          rsp0_zero, rsp1_zero, rsp0_err, rsp1_err;
    logic [W-1:0]  src_A, src_B, ALU_result;
    logic [2:0]    ALU_control;
    logic          zero;
    logic          busy, grant_id;

    alu_arbiter #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_A(req0_A), .req0_B(req0_B), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_A(req1_A), .req1_B(req1_B), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err),
        .src_A(src_A), .src_B(src_B), .ALU_control(ALU_control),
        .ALU_result(ALU_result), .zero(zero),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clock = ~clock;

    function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd5:    return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            default: return '0;
        endcase
    endfunction

    function automatic bit legal_op(input logic [2:0] op);
        return (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (op == 3'd3) || (op == 3'd5);
    endfunction

    assign ALU_result = alu_f(src_A, src_B, ALU_control);
    assign zero       = (ALU_result == '0);

    typedef struct {
        logic         id;
        logic [W-1:0] a, b;
        logic [2:0]   op;
        logic [W-1:0] res;
        logic         z, e;
        int           acc;
    } exp_t;

    exp_t  sb[$];
    exp_t  me;
    int    dut_order[$];
    int    cyc = 0;
    int    checks = 0, passes = 0;
    int    n_sent = 0, n_done = 0, n_abort = 0;
    bit    m_busy = 0;
    logic  m_ptr = 1'b0;
    bit    rr_rand = 0;
    logic  rdy0_fix = 1'b0, rdy1_fix = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        #2;
        rsp0_ready = rr_rand ? ($urandom_range(0, 3) != 0) : rdy0_fix;
        rsp1_ready = rr_rand ? ($urandom_range(0, 3) != 0) : rdy1_fix;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: compares DUT behaviour against the transaction model every cycle.
    always @(negedge clock) begin
        logic       win, in_resp, fire;
        logic [1:0] exp_rdy;
        int         lat;
        if (!reset) begin
            check("reset_handshakes", 128'({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy}), 128'(0));
            if (m_busy) n_abort++;
            sb.delete();
            m_busy = 0;
            m_ptr  = 1'b0;
        end else begin
            check("busy", 128'(busy), 128'(m_busy));
            if (m_busy) begin
                me      = sb[0];
                lat     = legal_op(me.op) ? 2 : 1;
                in_resp = (cyc >= me.acc + lat);
                check("ready_while_busy", 128'({req1_ready, req0_ready}), 128'(0));
                check("grant_id", 128'(grant_id), 128'(me.id));
                check("alu_drive", 128'({src_A, src_B, ALU_control}), 128'({me.a, me.b, me.op}));
                check("rsp_valid", 128'({rsp1_valid, rsp0_valid}),
                      128'({in_resp & me.id, in_resp & ~me.id}));
                if (in_resp) begin
                    check("rsp0_data", 128'({rsp0_result, rsp0_zero, rsp0_err}), 128'({me.res, me.z, me.e}));
                    check("rsp1_data", 128'({rsp1_result, rsp1_zero, rsp1_err}), 128'({me.res, me.z, me.e}));
                    fire = me.id ? rsp1_ready : rsp0_ready;
                    if (fire) begin
                        dut_order.push_back(rsp1_valid ? 1 : 0);
                        void'(sb.pop_front());
                        m_busy = 0;
                        m_ptr  = ~me.id;
                        n_done++;
                    end
                end
            end else begin
                win     = (req0_valid && req1_valid) ? m_ptr : req1_valid;
                exp_rdy = (req0_valid || req1_valid) ? (win ? 2'b10 : 2'b01) : 2'b00;
                check("arb_ready", 128'({req1_ready, req0_ready}), 128'(exp_rdy));
                check("rsp_valid_idle", 128'({rsp1_valid, rsp0_valid}), 128'(0));
                if (req0_valid || req1_valid) begin
                    me.id  = win;
                    me.a   = win ? req1_A  : req0_A;
                    me.b   = win ? req1_B  : req0_B;
                    me.op  = win ? req1_op : req0_op;
                    me.e   = !legal_op(me.op);
                    me.res = me.e ? '0 : alu_f(me.a, me.b, me.op);
                    me.z   = (me.res == '0);
                    me.acc = cyc;
                    sb.push_back(me);
                    m_busy = 1;
                end
            end
        end
    end

    task automatic send(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
        bit got = 0;
        if (id) begin req1_valid = 1'b1; req1_A = a; req1_B = b; req1_op = op; end
        else    begin req0_valid = 1'b1; req0_A = a; req0_B = b; req0_op = op; end
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (id ? req1_ready : req0_ready) begin got = 1; break; end
        end
        @(posedge clock); #1;
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
        if (got) n_sent++;
        else begin
            checks++;
            $display("FAIL accept_timeout: requester %0d got no ready, expected accept", id);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(posedge clock); #1;
            if (!m_busy) return;
        end
        checks++;
        $display("FAIL idle_timeout: model still busy, expected idle");
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
    endtask

    task automatic rand_traffic(input logic id, input int n);
        logic [W-1:0] a, b;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 3)) @(posedge clock);
            #0;
            a = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 3)) : W'($urandom);
            b = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 3)) : W'($urandom);
            send(id, a, b, 3'($urandom_range(0, 7)));
        end
    endtask

    initial begin
        repeat (60000) @(posedge clock);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        check("reset_regs", 128'({src_A, src_B, ALU_control, grant_id, rsp0_result, rsp0_zero, rsp0_err}), 128'(0));
        rdy0_fix = 1'b1; rdy1_fix = 1'b1;
        @(posedge clock); #1;

        // single requester subtract, then both requesting from reset
        send(1'b0, 32'd7, 32'd5, 3'b001);
        wait_idle();
        do_reset();
        dut_order.delete();
        fork
            begin
                send(1'b0, 32'd3, 32'd4, 3'b000);
                send(1'b0, 32'd10, 32'd1, 3'b001);
            end
            send(1'b1, 32'h0000_00F0, 32'h0000_000F, 3'b010);
        join
        wait_idle();
        check("rr_order", 128'({dut_order.size(), (dut_order.size() == 3) ? {dut_order[0], dut_order[1], dut_order[2]} : {3{32'hFFFF_FFFF}}}),
              128'({32'd3, 32'd0, 32'd1, 32'd0}));

        // signed compare, illegal op, then a legal op giving zero
        send(1'b1, 32'hFFFF_FFFF, 32'd1, 3'b101);
        send(1'b1, 32'd1, 32'hFFFF_FFFF, 3'b101);
        send(1'b0, 32'h1234, 32'h5678, 3'b110);
        send(1'b0, 32'd9, 32'd9, 3'b001);
        wait_idle();

        // response stall with a competing requester, and a withdrawn request
        rdy0_fix = 1'b0;
        send(1'b0, 32'hAAAA_0000, 32'h0000_5555, 3'b011);
        req1_valid = 1'b1; req1_A = 32'd1; req1_B = 32'd2; req1_op = 3'b000;
        @(posedge clock); #1 req1_valid = 1'b0;
        fork
            send(1'b1, 32'd20, 32'd22, 3'b000);
            begin
                repeat (6) @(posedge clock);
                #1 rdy0_fix = 1'b1;
            end
        join
        wait_idle();

        // reset while a response is pending
        rdy0_fix = 1'b0;
        send(1'b0, 32'd2, 32'd2, 3'b000);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock); #1 reset = 1'b1;
        check("abort_regs", 128'({src_A, src_B, ALU_control, grant_id, rsp0_result, rsp0_zero, rsp0_err, busy}), 128'(0));
        repeat (4) @(posedge clock);
        #1 rdy0_fix = 1'b1;

        // random traffic from both requesters with random response backpressure
        rr_rand = 1;
        fork
            rand_traffic(1'b0, 60);
            rand_traffic(1'b1, 60);
        join
        wait_idle();
        rr_rand = 0;
        repeat (3) @(posedge clock);

        check("all_responses", 128'({n_done, sb.size()}), 128'({n_sent - n_abort, 32'd0}));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
